// File: rtl/mem_str_fwd_queue.sv
// mem_str_fwd_queue
// Store queue that sits between the memory stage and data memory.
// Each accepted store captures its address plus data taken from a one-hot
// forwarding select across NSRC pipeline sources. Entries drain in FIFO
// order to data memory under a valid/ready handshake.
//
// Optional build feature:
//   STR_FWD_SEL_CHK_EN - when defined, sel_err latches high after any accepted
//                        store whose forwarding select is not exactly one-hot.
//                        When undefined, sel_err is tied low and no check
//                        logic exists.
module mem_str_fwd_queue #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 12,
  parameter int NSRC   = 3,
  parameter int DEPTH  = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     str_valid,
  input  logic [NSRC-1:0]          str_sel,
  input  logic [NSRC*DATA_W-1:0]   src_data,
  input  logic [ADDR_W-1:0]        str_addr,
  output logic                     str_stall,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     sel_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + DATA_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
  localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);

  // AND-OR forwarding mux: every selected source contributes its bits, so a
  // malformed select degrades to an OR rather than an undefined pick.
  function automatic logic [DATA_W-1:0] fwd_data(
    input logic [NSRC-1:0]        sel,
    input logic [NSRC*DATA_W-1:0] src
  );
    logic [DATA_W-1:0] acc;
    acc = {DATA_W{1'b0}};
    for (int i = 0; i < NSRC; i++) begin
      acc = acc | (src[i*DATA_W +: DATA_W] & {DATA_W{sel[i]}});
    end
    return acc;
  endfunction

  logic [ENT_W-1:0]  store_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;

  logic              full_s;
  logic              empty_s;
  logic              enq_s;
  logic              deq_s;
  logic [DATA_W-1:0] fwd_s;
  logic [ENT_W-1:0]  head_s;

  // Handshake decode from registered occupancy; a full queue never accepts,
  // even when the head is leaving on the same edge.
  always_comb begin
    full_s  = (count_r == FULL_CNT);
    empty_s = (count_r == {CNT_W{1'b0}});
    enq_s   = str_valid & ~full_s;
    deq_s   = ~empty_s & mem_ready;
    fwd_s   = fwd_data(str_sel, src_data);
    head_s  = store_r[rd_ptr_r];
  end

  // Pointer and occupancy state; pointers wrap naturally at DEPTH.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (enq_s) begin
        wr_ptr_r <= wr_ptr_r + ONE_PTR;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (deq_s) begin
        rd_ptr_r <= rd_ptr_r + ONE_PTR;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({enq_s, deq_s})
        2'b10:   count_r <= count_r + ONE_CNT;
        2'b01:   count_r <= count_r - ONE_CNT;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written, outputs are masked.
  always_ff @(posedge clock) begin
    if (enq_s) begin
      store_r[wr_ptr_r] <= {str_addr, fwd_s};
    end
  end

  // Head presentation, forced to zero while the queue is empty.
  always_comb begin
    str_stall = full_s;
    mem_valid = ~empty_s;
    count     = count_r;
    if (empty_s) begin
      mem_addr = {ADDR_W{1'b0}};
      mem_data = {DATA_W{1'b0}};
    end else begin
      mem_addr = head_s[ENT_W-1:DATA_W];
      mem_data = head_s[DATA_W-1:0];
    end
  end

`ifdef STR_FWD_SEL_CHK_EN
  // Exactly one bit set in the forwarding select.
  function automatic logic is_onehot(input logic [NSRC-1:0] sel);
    int ones;
    ones = 0;
    for (int i = 0; i < NSRC; i++) begin
      ones = ones + int'(sel[i]);
    end
    return (ones == 1);
  endfunction

  logic sel_err_r;

  // Sticky select-violation flag, cleared only by reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sel_err_r <= 1'b0;
    end else if (enq_s && !is_onehot(str_sel)) begin
      sel_err_r <= 1'b1;
    end else begin
      sel_err_r <= sel_err_r;
    end
  end

  assign sel_err = sel_err_r;
`else
  assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_str_fwd_queue.sv
// Self-checking bench for mem_str_fwd_queue: directed scenarios plus random
// traffic, with an expected-entry scoreboard consumed by a head monitor.
module tb_mem_str_fwd_queue;

  localparam int DATA_W = 12;
  localparam int ADDR_W = 12;
  localparam int NSRC   = 3;
  localparam int DEPTH  = 4;
  localparam int ENT_W  = ADDR_W + DATA_W;
`ifdef STR_FWD_SEL_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic                   clock;
  logic                   reset_n;
  logic                   str_valid;
  logic [NSRC-1:0]        str_sel;
  logic [NSRC*DATA_W-1:0] src_data;
  logic [ADDR_W-1:0]      str_addr;
  logic                   str_stall;
  logic                   mem_valid;
  logic                   mem_ready;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_data;
  logic [$clog2(DEPTH):0] count;
  logic                   sel_err;

  mem_str_fwd_queue #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NSRC(NSRC), .DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset_n(reset_n), .str_valid(str_valid), .str_sel(str_sel),
    .src_data(src_data), .str_addr(str_addr), .str_stall(str_stall),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_data(mem_data), .count(count), .sel_err(sel_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int model_cnt = 0;
  bit exp_err = 1'b0;
  bit done = 1'b0;
  logic [ENT_W-1:0] exp_q[$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference forwarding: OR of every selected source word.
  function automatic logic [DATA_W-1:0] ref_fwd(input logic [NSRC-1:0] sel,
                                               input logic [NSRC*DATA_W-1:0] src);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < NSRC; i++) if (sel[i]) r = r | src[i*DATA_W +: DATA_W];
    return r;
  endfunction

  function automatic int popc(input logic [NSRC-1:0] sel);
    int n;
    n = 0;
    for (int i = 0; i < NSRC; i++) if (sel[i]) n++;
    return n;
  endfunction

  function automatic logic [NSRC*DATA_W-1:0] rnd_src();
    logic [NSRC*DATA_W-1:0] s;
    for (int i = 0; i < NSRC; i++) s[i*DATA_W +: DATA_W] = DATA_W'($urandom);
    return s;
  endfunction

  function automatic logic [NSRC-1:0] rnd_sel();
    logic [NSRC-1:0] s;
    if ($urandom_range(0, 9) < 8) begin
      s = '0;
      s[$urandom_range(0, NSRC-1)] = 1'b1;
    end else begin
      s = NSRC'($urandom);
    end
    return s;
  endfunction

  // One clock cycle: drive (called at posedge+1), check state at negedge,
  // record expected entry when the store is accepted, advance model occupancy.
  task automatic cycle(input logic v, input logic [NSRC-1:0] s,
                       input logic [NSRC*DATA_W-1:0] src, input logic [ADDR_W-1:0] a,
                       input logic r);
    bit acc;
    bit dq;
    str_valid = v; str_sel = s; src_data = src; str_addr = a; mem_ready = r;
    @(negedge clock);
    chk("count", 32'(count), 32'(model_cnt));
    chk("str_stall", 32'(str_stall), 32'(model_cnt == DEPTH));
    chk("mem_valid", 32'(mem_valid), 32'(model_cnt != 0));
    chk("sel_err", 32'(sel_err), 32'(exp_err));
    if (model_cnt == 0) chk("empty_mask", {8'h00, mem_addr, mem_data}, 32'h0);
    acc = v && (model_cnt < DEPTH);
    dq  = r && (model_cnt > 0);
    if (acc) begin
      exp_q.push_back({a, ref_fwd(s, src)});
      if (CHK_EN && popc(s) != 1) exp_err = 1'b1;
    end
    model_cnt = model_cnt + int'(acc) - int'(dq);
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input logic r);
    cycle(1'b0, '0, '0, '0, r);
  endtask

  task automatic enq_rnd(input logic r);
    cycle(1'b1, rnd_sel(), rnd_src(), ADDR_W'($urandom), r);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
  endtask

  initial begin
    logic [NSRC*DATA_W-1:0] src;
    reset_n = 1'b0; str_valid = 1'b0; str_sel = '0; src_data = '0;
    str_addr = '0; mem_ready = 1'b0;
    fork
      begin
        #12;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(mem_valid), 32'd0);
        chk("rst_stall", 32'(str_stall), 32'd0);
        chk("rst_err", 32'(sel_err), 32'd0);
        chk("rst_head", {8'h00, mem_addr, mem_data}, 32'h0);
        @(negedge clock); #2 reset_n = 1'b1;
        @(posedge clock); #1;

        // Single forwarded store from source 1.
        src = '0;
        src[1*DATA_W +: DATA_W] = 12'hA5C;
        src[0*DATA_W +: DATA_W] = 12'h111;
        src[2*DATA_W +: DATA_W] = 12'h222;
        cycle(1'b1, 3'b010, src, 12'h010, 1'b0);
        chk("first_valid", 32'(mem_valid), 32'd1);
        chk("first_data", 32'(mem_data), 32'h0000_0A5C);
        chk("first_addr", 32'(mem_addr), 32'h0000_0010);
        chk("first_count", 32'(count), 32'd1);
        idle(1'b0);
        drain();

        // Overfill: fifth store dropped, then in-order drain.
        for (int i = 0; i < 5; i++) enq_rnd(1'b0);
        chk("full_stall", 32'(str_stall), 32'd1);
        drain();

        // Full with simultaneous store and dequeue: only the dequeue happens.
        for (int i = 0; i < DEPTH; i++) enq_rnd(1'b0);
        enq_rnd(1'b1);
        chk("full_deq_count", 32'(count), 32'd3);
        chk("full_deq_stall", 32'(str_stall), 32'd0);
        drain();

        // Steady state at two entries with pointer wrap.
        enq_rnd(1'b0); enq_rnd(1'b0);
        for (int i = 0; i < 10; i++) enq_rnd(1'b1);
        chk("steady_count", 32'(count), 32'd2);
        drain();

        // Malformed select: data is the OR of both sources.
        src = rnd_src();
        cycle(1'b1, 3'b011, src, 12'h3C3, 1'b0);
        chk("or_data", 32'(mem_data),
            32'(src[0 +: DATA_W] | src[DATA_W +: DATA_W]));
        idle(1'b0);
        idle(1'b1);

        // Asynchronous reset with three entries queued.
        for (int i = 0; i < 3; i++) enq_rnd(1'b0);
        chk("pre_rst_count", 32'(count), 32'd3);
        #1 reset_n = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_valid", 32'(mem_valid), 32'd0);
        chk("arst_head", {8'h00, mem_addr, mem_data}, 32'h0);
        chk("arst_err", 32'(sel_err), 32'd0);
        exp_q.delete(); model_cnt = 0; exp_err = 1'b0;
        str_valid = 1'b0; mem_ready = 1'b1;
        @(negedge clock); #2 reset_n = 1'b1;
        @(posedge clock); #1;
        idle(1'b1);

        // Random traffic with varying drain pressure.
        for (int i = 0; i < 400; i++) begin
          int rp;
          rp = (i / 50) % 4;
          cycle(logic'($urandom_range(0, 9) < 7), rnd_sel(), rnd_src(),
                ADDR_W'($urandom), logic'($urandom_range(0, 3) < rp + 1));
        end
        drain();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        done = 1'b1;
      end
      begin
        // Head monitor: every presented head must match the oldest expected entry.
        while (!done) begin
          @(negedge clock);
          if (reset_n && mem_valid) begin
            if (exp_q.size() == 0) begin
              chk("head_unexpected", 32'(mem_valid), 32'd0);
            end else begin
              chk("head", {8'h00, mem_addr, mem_data}, 32'(exp_q[0]));
              if (mem_ready) void'(exp_q.pop_front());
            end
          end
        end
      end
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
